// File: rtl/bcd_gray_word_conv_if.sv
// Handshake bundle for the multi-digit BCD/Gray word converter.
// Carries input word, output word, per-digit errors and busy.
interface bcd_gray_word_conv_if #(
  parameter int DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_data;
  logic                  in_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   out_data;
  logic [DIGITS-1:0]     out_err;
  logic                  busy;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_mode,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_err,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    output in_mode,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_err,
    input  busy
  );
endinterface

// File: rtl/bcd_gray_word_conv.sv
// Serial BCD<->Gray word converter, one digit per clock.
// Illegal digits become 4'hF and raise their out_err bit.
module bcd_gray_word_conv #(
  parameter int DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_gray_word_conv_if.slave cv
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [4*DIGITS-1:0] src_q;
  logic                mode_q;
  logic [4*DIGITS-1:0] res_q;
  logic [DIGITS-1:0]   err_q;
  logic                rdy_q;
  logic                vld_q;
  logic                busy_q;
  logic [3:0]          dig_d;
  logic                err_d;

  // Returns {illegal, converted digit}.
  function automatic logic [4:0] conv_digit(
    input logic [3:0] d,
    input logic       m
  );
    logic [4:0] r;
    r = 5'h1f;
    if (!m) begin
      if (d <= 4'd9) r = {1'b0, d ^ {1'b0, d[3:1]}};
    end else begin
      case (d)
        4'h0:    r = 5'h00;
        4'h1:    r = 5'h01;
        4'h3:    r = 5'h02;
        4'h2:    r = 5'h03;
        4'h6:    r = 5'h04;
        4'h7:    r = 5'h05;
        4'h5:    r = 5'h06;
        4'h4:    r = 5'h07;
        4'hC:    r = 5'h08;
        4'hD:    r = 5'h09;
        default: r = 5'h1f;
      endcase
    end
    return r;
  endfunction

  // Convert the digit currently selected by the index.
  always_comb begin
    dig_d = 4'h0;
    err_d = 1'b0;
    {err_d, dig_d} = conv_digit(src_q[{idx_q, 2'b00} +: 4], mode_q);
  end

  // Control FSM with registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      src_q   <= '0;
      mode_q  <= 1'b0;
      res_q   <= '0;
      err_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cv.in_valid) begin
            src_q   <= cv.in_data;
            mode_q  <= cv.in_mode;
            res_q   <= '0;
            err_q   <= '0;
            idx_q   <= '0;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          res_q[{idx_q, 2'b00} +: 4] <= dig_d;
          err_q[idx_q] <= err_d;
          if (idx_q == LAST) begin
            vld_q   <= 1'b1;
            state_q <= HOLD;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        HOLD: begin
          if (cv.out_ready) begin
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cv.in_ready  = rdy_q;
  assign cv.out_valid = vld_q;
  assign cv.out_data  = res_q;
  assign cv.out_err   = err_q;
  assign cv.busy      = busy_q;
endmodule

// File: tb/tb_bcd_gray_word_conv.sv
// Randomised self-checking bench for bcd_gray_word_conv.
// Reference model works digit-by-digit from the Gray table.
module tb_bcd_gray_word_conv;
  localparam int D = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  bit   pending;
  logic [15:0] exp_d;
  logic [3:0]  exp_e;

  bcd_gray_word_conv_if #(.DIGITS(D)) cv ();

  bcd_gray_word_conv #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cv    (cv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [15:0] d, input logic m,
                                output logic [15:0] od,
                                output logic [3:0] oe);
    int g [10];
    int v;
    g = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13};
    od = 16'hFFFF;
    oe = 4'hF;
    for (int i = 0; i < D; i++) begin
      v = int'(d[4*i +: 4]);
      if (!m) begin
        if (v < 10) begin
          od[4*i +: 4] = 4'(g[v]);
          oe[i] = 1'b0;
        end
      end else begin
        for (int j = 0; j < 10; j++) begin
          if (g[j] == v) begin
            od[4*i +: 4] = 4'(j);
            oe[i] = 1'b0;
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_vs_busy", {31'd0, cv.in_ready}, {31'd0, !cv.busy});
      if (cv.out_valid) begin
        chk("out_expected", {31'd0, pending}, 32'd1);
        chk("busy_in_hold", {31'd0, cv.busy}, 32'd1);
        chk("mon_data", {16'd0, cv.out_data}, {16'd0, exp_d});
        chk("mon_err", {28'd0, cv.out_err}, {28'd0, exp_e});
      end
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cv.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("in_ready_wait", {31'd0, ok}, 32'd1);
  endtask

  task automatic accept(input logic [15:0] d, input logic m);
    model(d, m, exp_d, exp_e);
    wait_ready();
    cv.in_valid  = 1'b1;
    cv.in_data   = d;
    cv.in_mode   = m;
    cv.out_ready = 1'b0;
    @(posedge clk);
    pending = 1'b1;
    #1;
    cv.in_valid = 1'b0;
    cv.in_data  = 16'($urandom);
    cv.in_mode  = 1'($urandom);
    chk("busy_after_accept", {31'd0, cv.busy}, 32'd1);
  endtask

  task automatic xfer(input logic [15:0] d, input logic m,
                      input int stall, input bit lit,
                      input logic [15:0] ld, input logic [3:0] le);
    int k;
    logic [15:0] md;
    logic [3:0]  me;
    if (lit) begin
      model(d, m, md, me);
      chk("model_data", {16'd0, md}, {16'd0, ld});
      chk("model_err", {28'd0, me}, {28'd0, le});
    end
    accept(d, m);
    k = 0;
    while (!cv.out_valid && k < D + 4) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", k, D);
    if (lit) begin
      chk("out_data", {16'd0, cv.out_data}, {16'd0, ld});
      chk("out_err", {28'd0, cv.out_err}, {28'd0, le});
    end
    repeat (stall) begin
      cv.in_valid = 1'($urandom);
      cv.in_data  = 16'($urandom);
      cv.in_mode  = 1'($urandom);
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, cv.out_valid}, 32'd1);
      chk("hold_not_ready", {31'd0, cv.in_ready}, 32'd0);
    end
    cv.in_valid  = 1'b1;
    cv.in_data   = 16'($urandom);
    cv.out_ready = 1'b1;
    @(posedge clk);
    pending = 1'b0;
    #1;
    cv.out_ready = 1'b0;
    chk("ready_after_hs", {31'd0, cv.in_ready}, 32'd1);
    chk("valid_after_hs", {31'd0, cv.out_valid}, 32'd0);
    cv.in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, {31'd0, cv.in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, cv.out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'd0, cv.busy}, 32'd0);
    chk({tag, "_out_data"}, {16'd0, cv.out_data}, 32'd0);
    chk({tag, "_out_err"}, {28'd0, cv.out_err}, 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] gd;
    logic [3:0]  ge;
    logic        m;
    bit          seen;
    n_chk = 0;
    n_fail = 0;
    pending = 1'b0;
    exp_d = '0;
    exp_e = '0;
    rst_n = 1'b1;
    cv.in_valid  = 1'b0;
    cv.in_data   = '0;
    cv.in_mode   = 1'b0;
    cv.out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_vals("rst0");
    #13 rst_n = 1'b1;
    @(posedge clk);
    #1;

    xfer(16'h9876, 1'b0, 0, 1'b1, 16'hDC45, 4'b0000);
    xfer(16'h12A3, 1'b0, 1, 1'b1, 16'h13F2, 4'b0010);
    xfer(16'hDC45, 1'b1, 0, 1'b1, 16'h9876, 4'b0000);
    xfer(16'h8C45, 1'b1, 2, 1'b1, 16'hF876, 4'b1000);
    xfer(16'hFFFF, 1'b0, 0, 1'b1, 16'hFFFF, 4'b1111);
    xfer(16'h9876, 1'b0, 5, 1'b1, 16'hDC45, 4'b0000);

    accept(16'h5555, 1'b0);
    repeat (D) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    pending = 1'b0;
    #1 check_reset_vals("rst_hold");
    @(negedge clk);
    #2 rst_n = 1'b1;

    accept(16'h4321, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    pending = 1'b0;
    #1 check_reset_vals("rst_conv");
    @(negedge clk);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (D + 3) begin
      @(posedge clk);
      #1;
      if (cv.out_valid) seen = 1'b1;
    end
    chk("aborted_no_output", {31'd0, seen}, 32'd0);
    xfer(16'h0000, 1'b0, 0, 1'b1, 16'h0000, 4'b0000);

    for (int n = 0; n < 150; n++) begin
      d = 16'($urandom);
      m = 1'($urandom);
      if (m && ($urandom_range(0, 3) != 0)) begin
        for (int i = 0; i < D; i++)
          d[4*i +: 4] = 4'($urandom_range(0, 9));
        model(d, 1'b0, gd, ge);
        d = gd;
      end
      xfer(d, m, $urandom_range(0, 3), 1'b0, 16'h0, 4'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_gray_word_conv.md
# bcd_gray_word_conv

Multi-digit, bidirectional BCD/Gray code converter with a valid/ready handshake on both sides. It is the parametrised successor of the single-digit combinational BCD-to-Gray converter. It accepts a packed word of DIGITS 4-bit digits and converts it serially, one digit per clock, through a single shared digit-conversion function. It flags every digit that falls outside the 10-code set and holds the result until the downstream consumer accepts it. It sits between a BCD source (counter, keypad decoder) and a Gray-coded sink (display driver, cross-domain pointer logic), or the reverse.

## Interface
Parameters:
- DIGITS, 4, number of 4-bit digits per word; legal range 1..16.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  in_data/in_mode are valid.
- in_ready  output  1  block can accept a word.
- in_data  input  4*DIGITS  packed digits; digit i = in_data[4i+3:4i].
- in_mode  input  1  0 = BCD→Gray, 1 = Gray→BCD; captured with the word.
- out_valid  output  1  out_data/out_err are valid.
- out_ready  input  1  consumer accepts the output.
- out_data  output  4*DIGITS  converted digits, same packing as in_data.
- out_err  output  DIGITS  bit i set when input digit i was not a legal code.
- busy  output  1  high in CONV or HOLD.

## Operation
- Legal code set:
  - BCD 0..9 maps to Gray 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101.
  - Mode 1 is the exact inverse of this mapping.
- Illegal input digits:
  - Mode 0: BCD 10..15.
  - Mode 1: any Gray code not in the set above.
  - Result digit = 4'b1111; the matching out_err bit is set to 1.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, the edge captures in_data and in_mode into the input register, clears the result and error registers, sets digit index to 0, and moves to CONV.
  - CONV: each cycle converts the digit at the current index and writes it into the result register at the same position, then increments the index. After the edge that converts digit DIGITS-1, move to HOLD.
  - HOLD: out_valid=1. out_data and out_err are stable. On out_valid&&out_ready, move to IDLE.
- Input and output handshake edges never coincide; no new word is accepted in the HOLD-exit cycle.
- Changes on in_data, in_valid or in_mode outside IDLE are ignored.
- Digit index width: clog2(DIGITS), minimum 1 bit. The index never wraps past DIGITS-1.
- out_data and out_err are driven from registers only; no combinational path from any input to any output.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0, out_err=0, state=IDLE, index=0.
- Reset asserted mid-CONV or mid-HOLD aborts the word immediately; no output is produced for it.
- Latency: out_valid rises DIGITS clock edges after the accepting edge.
- in_ready rises one cycle after the output handshake edge.
- Maximum throughput: one word per DIGITS+2 cycles when out_ready is held at 1.
- out_ready low in HOLD stalls indefinitely; outputs are held bit-stable.
- DIGITS=1: CONV lasts exactly one cycle.

## Test plan
- Reset state: pulse rst_n low asynchronously (not aligned to clk) → in_ready=1, out_valid=0, busy=0, out_data=0, out_err=0, all immediately on assertion.
- Forward, DIGITS=4:
  - Stimulus: mode 0, in_data=16'h9876.
  - Response: out_valid exactly 4 edges after accept; out_data=16'hDC45, out_err=4'b0000.
- Forward with illegal digit:
  - Stimulus: mode 0, in_data=16'h12A3.
  - Response: out_data=16'h13F2, out_err=4'b0010.
- Inverse with illegal digit:
  - Case 1: mode 1, in_data=16'hDC45 → out_data=16'h9876, err=0.
  - Case 2: mode 1, in_data=16'h8C45 → out_data=16'hF876, out_err=4'b1000.
- Backpressure and ignored input:
  - Stimulus: hold out_ready=0 for 5 cycles in HOLD while toggling in_data and in_valid.
  - Response: out_data stable throughout; in_ready=0; no capture occurs. After out_ready=1, in_ready=1 on the next cycle.
- Reset mid-operation:
  - Stimulus: assert rst_n low during the second CONV cycle, release it, then send 16'h0000.
  - Response: no out_valid for the aborted word; the new word yields out_data=16'h0000, err=0.
